// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NREQ byte requesters
//
// Optional feature macro: UART_ARB_TAG_EN
//   When defined, each grant first transmits the tag byte 8'hF0 | grant_id,
//   then the requester's data byte. A timeout on the tag also drops the data.
//
// Parameters:
//   NREQ          number of requesters (2..16)
//   IDW           width of grant_id, 2**IDW >= NREQ
//   START_TIMEOUT cycles allowed after wr_en for tx_busy to rise (1..255)
//
// Ports:
//   clk_50m       in   sole clock, rising edge
//   rst_n         in   synchronous active-low reset
//   req           in   [NREQ]   per-requester level request
//   req_data      in   [8*NREQ] byte of requester i in bits [8i+7:8i]
//   ack           out  [NREQ]   one-cycle pulse, requester's byte latched
//   grant_id      out  [IDW]    index of the most recent grant
//   active        out  high whenever the arbiter is not idle
//   err_timeout   out  one-cycle pulse when tx_busy never rose
//   uart_din      out  [8]      byte to UART din
//   uart_wr_en    out  one-cycle write strobe to UART
//   uart_tx_busy  in   UART transmitter busy flag

module uart_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int IDW           = 2,
    parameter int START_TIMEOUT = 8
) (
    input  logic                clk_50m,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     ack,
    output logic [IDW-1:0]      grant_id,
    output logic                active,
    output logic                err_timeout,
    output logic [7:0]          uart_din,
    output logic                uart_wr_en,
    input  logic                uart_tx_busy
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_ISSUE       = 3'd1;
    localparam logic [2:0] S_WAIT_HI     = 3'd2;
    localparam logic [2:0] S_WAIT_LO     = 3'd3;
`ifdef UART_ARB_TAG_EN
    localparam logic [2:0] S_TAG_ISSUE   = 3'd4;
    localparam logic [2:0] S_TAG_WAIT_HI = 3'd5;
    localparam logic [2:0] S_TAG_WAIT_LO = 3'd6;
`endif

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(START_TIMEOUT);

    logic [2:0]      state;
    logic [IDW-1:0]  ptr;
    logic [7:0]      hold;
    logic [7:0]      cnt;

    logic            found;
    logic [IDW-1:0]  winner;
    logic [7:0]      win_byte;
    logic [NREQ-1:0] win_onehot;

    // Round-robin search starting at ptr+1 and wrapping: first look at
    // indices above ptr, then fall back to indices 0..ptr. Constant loop
    // indices keep the selection a plain priority mux.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        win_byte = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i > int'(ptr))) begin
                found    = 1'b1;
                winner   = IDW'(i);
                win_byte = req_data[8*i +: 8];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i <= int'(ptr))) begin
                found    = 1'b1;
                winner   = IDW'(i);
                win_byte = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == winner) begin
                win_onehot[i] = 1'b1;
            end
        end
    end

    assign active = (state != S_IDLE);

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ptr         <= IDW'(NREQ - 1);
            hold        <= 8'h00;
            cnt         <= 8'h00;
            ack         <= '0;
            grant_id    <= '0;
            err_timeout <= 1'b0;
            uart_din    <= 8'h00;
            uart_wr_en  <= 1'b0;
        end else begin
            // Pulsed outputs default low every cycle.
            ack         <= '0;
            err_timeout <= 1'b0;
            uart_wr_en  <= 1'b0;

            case (state)
                S_IDLE: begin
                    // A busy UART in IDLE means a frame is still in flight
                    // (e.g. reset landed mid-frame); wait for it to finish.
                    if (!uart_tx_busy && found) begin
                        hold     <= win_byte;
                        grant_id <= winner;
                        ptr      <= winner;
                        ack      <= win_onehot;
`ifdef UART_ARB_TAG_EN
                        state    <= S_TAG_ISSUE;
`else
                        state    <= S_ISSUE;
`endif
                    end
                end

`ifdef UART_ARB_TAG_EN
                S_TAG_ISSUE: begin
                    uart_din   <= 8'hF0 | 8'(grant_id);
                    uart_wr_en <= 1'b1;
                    cnt        <= 8'h00;
                    state      <= S_TAG_WAIT_HI;
                end

                S_TAG_WAIT_HI: begin
                    if (uart_tx_busy) begin
                        state <= S_TAG_WAIT_LO;
                    end else if (cnt == TIMEOUT_LIMIT) begin
                        // Tag never started: abandon the data byte too.
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                S_TAG_WAIT_LO: begin
                    if (!uart_tx_busy) begin
                        state <= S_ISSUE;
                    end
                end
`endif

                S_ISSUE: begin
                    uart_din   <= hold;
                    uart_wr_en <= 1'b1;
                    cnt        <= 8'h00;
                    state      <= S_WAIT_HI;
                end

                S_WAIT_HI: begin
                    if (uart_tx_busy) begin
                        state <= S_WAIT_LO;
                    end else if (cnt == TIMEOUT_LIMIT) begin
                        // Byte is dropped; no retry.
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                S_WAIT_LO: begin
                    if (!uart_tx_busy) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a behavioural UART and requester model

module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TO   = 8;
`ifdef UART_ARB_TAG_EN
    localparam int WPB  = 2;
`else
    localparam int WPB  = 1;
`endif

    logic               clk_50m = 1'b0;
    logic               rst_n   = 1'b0;
    logic [NREQ-1:0]    req;
    logic [8*NREQ-1:0]  req_data;
    logic [NREQ-1:0]    ack;
    logic [IDW-1:0]     grant_id;
    logic               active;
    logic               err_timeout;
    logic [7:0]         uart_din;
    logic               uart_wr_en;
    logic               uart_tx_busy = 1'b0;

    logic [NREQ-1:0]    auto_req  = '0;
    logic [NREQ-1:0]    extra_req = '0;
    logic [8*NREQ-1:0]  auto_data = '0;

    assign req      = auto_req | extra_req;
    assign req_data = auto_data;

    always #10 clk_50m = ~clk_50m;

    uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .START_TIMEOUT(TO)) dut (
        .clk_50m      (clk_50m),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .grant_id     (grant_id),
        .active       (active),
        .err_timeout  (err_timeout),
        .uart_din     (uart_din),
        .uart_wr_en   (uart_wr_en),
        .uart_tx_busy (uart_tx_busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Per-requester byte queues, expected UART byte stream, logs.
    logic [7:0] rq [NREQ][$];
    logic [7:0] exp_bytes [$];
    logic [7:0] recv_log [$];
    int         grant_log [$];
    int         ack_cnt [NREQ];
    int         wr_cnt = 0, err_cnt = 0, ack_total = 0;
    int         cyc = 0, ack_cyc = -100, last_wr_cyc = -100, fall_cyc = -100;
    bit         fall_pending = 1'b0;
    int         model_ptr = NREQ - 1;
    logic [NREQ-1:0]   req_prev  = '0;
    logic [8*NREQ-1:0] data_prev = '0;
    logic       busy_prev = 1'b0;
    logic [7:0] last_din = 8'h00;
    logic [7:0] exp_b;
    int         mw, mew, mi;
    bit         chk_lat   = 1'b0;
    int         frame_len = 4;
    bit         uart_dead = 1'b0;

    // Behavioural UART: busy rises the cycle after wr_en and stays high
    // for frame_len cycles. When dead, it ignores writes.
    always begin
        @(negedge clk_50m);
        if (uart_wr_en && !uart_dead) begin
            @(posedge clk_50m);
            #1 uart_tx_busy = 1'b1;
            repeat (frame_len) @(posedge clk_50m);
            #1 uart_tx_busy = 1'b0;
        end
    end

    // Requesters: hold req/data for the queue head until ack is seen.
    logic [NREQ-1:0] ack_seen;
    always begin
        @(negedge clk_50m);
        ack_seen = ack;
        @(posedge clk_50m);
        #2;
        for (int i = 0; i < NREQ; i++) begin
            if (ack_seen[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            auto_req[i] = (rq[i].size() > 0);
            auto_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk_50m) begin
        cyc++;
        if (!rst_n) begin
            model_ptr = NREQ - 1;
            exp_bytes.delete();
            last_din = 8'h00;
        end else begin
            check("ack_onehot", 32'($countones(ack) <= 1), 1);
            check("ack_wr_excl", 32'((ack != 0) && uart_wr_en), 0);
            if (ack != 0) begin
                mw = -1;
                for (int i = 0; i < NREQ; i++) if (ack[i]) mw = i;
                mew = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    mi = (model_ptr + k) % NREQ;
                    if (mew < 0 && req_prev[mi]) mew = mi;
                end
                check("grant_winner", mw, mew);
                check("grant_id", 32'(grant_id), mw);
                check("grant_while_busy", 32'(busy_prev), 0);
`ifdef UART_ARB_TAG_EN
                exp_bytes.push_back(8'hF0 | 8'(mw));
`endif
                exp_bytes.push_back(data_prev[8*mw +: 8]);
                model_ptr = mw;
                ack_cnt[mw]++;
                ack_total++;
                ack_cyc = cyc;
                grant_log.push_back(mw);
            end
            if (uart_wr_en) begin
                if (exp_bytes.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    exp_b = exp_bytes.pop_front();
                    check("uart_din", 32'(uart_din), 32'(exp_b));
                end
                if (last_wr_cyc < ack_cyc) check("ack_to_wr", cyc - ack_cyc, 1);
                wr_cnt++;
                last_wr_cyc = cyc;
                last_din = uart_din;
                recv_log.push_back(uart_din);
            end else begin
                check("din_hold", 32'(uart_din), 32'(last_din));
            end
            if (err_timeout) begin
                check("timeout_delay", cyc - last_wr_cyc, TO + 1);
                check("idle_after_timeout", 32'(active), 0);
                check("timeout_expected", 32'(uart_dead), 1);
                exp_bytes.delete();
                err_cnt++;
            end
            if (chk_lat && cyc == fall_cyc + 2 && req_prev != 0 && !fall_pending)
                check("rearb_latency", 32'(ack != 0), 1);
            if (busy_prev && !uart_tx_busy) begin
                fall_cyc = cyc;
                fall_pending = (exp_bytes.size() != 0);
            end
        end
        req_prev  = req;
        data_prev = req_data;
        busy_prev = uart_tx_busy;
    end

    task automatic wait_idle(input string name);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 5000) begin
            @(negedge clk_50m);
            n++;
            done = (exp_bytes.size() == 0) && !uart_tx_busy && !active && (req == 0);
            for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) done = 1'b0;
        end
        check(name, 32'(done), 1);
        repeat (2) @(posedge clk_50m);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ack"}, 32'(ack), 0);
        check({tag, "_grant_id"}, 32'(grant_id), 0);
        check({tag, "_active"}, 32'(active), 0);
        check({tag, "_err"}, 32'(err_timeout), 0);
        check({tag, "_din"}, 32'(uart_din), 0);
        check({tag, "_wr_en"}, 32'(uart_wr_en), 0);
    endtask

    int b_wr, b_err, b_tot, enq, n;
    int b_ack [NREQ];

    task automatic snap();
        b_wr = wr_cnt; b_err = err_cnt; b_tot = ack_total;
        for (int i = 0; i < NREQ; i++) b_ack[i] = ack_cnt[i];
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk_50m);
        @(negedge clk_50m);
        check_zero_outputs("reset");
        @(posedge clk_50m);
        #1 rst_n = 1'b1;

        // Round-robin: all four requesters with two bytes each.
        chk_lat = 1'b1;
        @(posedge clk_50m);
        #1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) rq[i].push_back(8'(16 + i));
        wait_idle("rr_done");
        check("rr_grants", grant_log.size(), 8);
        check("rr_bytes", recv_log.size(), 8 * WPB);
        for (int k = 0; k < 8; k++) begin
            if (k < grant_log.size()) check("rr_order", grant_log[k], k % 4);
            if (k * WPB + WPB - 1 < recv_log.size())
                check("rr_byte", 32'(recv_log[k*WPB+WPB-1]), 16 + k % 4);
        end

        // Single request.
        snap();
        rq[0].push_back(8'h5A);
        wait_idle("single_done");
        check("single_ack", ack_cnt[0] - b_ack[0], 1);
        check("single_wr", wr_cnt - b_wr, WPB);
        check("single_byte", 32'(recv_log[recv_log.size()-1]), 32'h5A);
        check("single_active_low", 32'(active), 0);

        // Requester 2 with C3 (tag F2 first when tagging is built in).
        snap();
        rq[2].push_back(8'hC3);
        wait_idle("tag_done");
        check("tag_ack", ack_cnt[2] - b_ack[2], 1);
        check("tag_data", 32'(recv_log[recv_log.size()-1]), 32'hC3);
`ifdef UART_ARB_TAG_EN
        check("tag_byte", 32'(recv_log[recv_log.size()-2]), 32'hF2);
`endif

        // Withdrawn request: req[3] pulsed for one cycle while busy.
        snap();
        rq[1].push_back(8'h77);
        n = 0;
        while (!uart_tx_busy && n < 200) begin @(negedge clk_50m); n++; end
        check("withdraw_busy_seen", 32'(uart_tx_busy), 1);
        @(posedge clk_50m); #1 extra_req = 4'b1000;
        @(posedge clk_50m); #1 extra_req = 4'b0000;
        wait_idle("withdraw_done");
        check("withdraw_no_ack3", ack_cnt[3] - b_ack[3], 0);
        check("withdraw_ack1", ack_cnt[1] - b_ack[1], 1);
        check("withdraw_wr", wr_cnt - b_wr, WPB);

        // Timeout: UART never raises busy, then recovers.
        chk_lat = 1'b0;
        snap();
        uart_dead = 1'b1;
        rq[2].push_back(8'h99);
        n = 0;
        while (err_cnt == b_err && n < 300) begin @(negedge clk_50m); n++; end
        check("timeout_seen", err_cnt - b_err, 1);
        repeat (2) @(posedge clk_50m);
        #1 uart_dead = 1'b0;
        rq[2].push_back(8'h98);
        wait_idle("timeout_recover_done");
        check("timeout_single_err", err_cnt - b_err, 1);
        check("timeout_acks", ack_cnt[2] - b_ack[2], 2);
        check("timeout_wr", wr_cnt - b_wr, WPB + 1);
        check("timeout_next_byte", 32'(recv_log[recv_log.size()-1]), 32'h98);

        // Reset during WAIT_LO with a long frame in flight, req[1] held.
        snap();
        frame_len = 20;
        rq[1].push_back(8'h3C);
        rq[1].push_back(8'h3D);
        n = 0;
        while (wr_cnt < b_wr + WPB && n < 500) begin @(negedge clk_50m); n++; end
        while (!uart_tx_busy && n < 500) begin @(negedge clk_50m); n++; end
        check("rst_frame_started", 32'(uart_tx_busy), 1);
        repeat (3) @(posedge clk_50m);
        #1 rst_n = 1'b0;
        @(posedge clk_50m);
        @(negedge clk_50m);
        check_zero_outputs("midrst");
        rst_n = 1'b1;
        wait_idle("midrst_done");
        check("midrst_acks", ack_cnt[1] - b_ack[1], 2);
        check("midrst_wr", wr_cnt - b_wr, 2 * WPB);
        check("midrst_byte", 32'(recv_log[recv_log.size()-1]), 32'h3D);
        frame_len = 4;

        // Randomized traffic.
        chk_lat = 1'b1;
        for (int r = 0; r < 3; r++) begin
            snap();
            enq = 0;
            frame_len = $urandom_range(2, 6);
            for (int c = 0; c < 250; c++) begin
                @(posedge clk_50m);
                #1;
                if ($urandom_range(0, 5) == 0) begin
                    mi = $urandom_range(0, NREQ - 1);
                    if (rq[mi].size() < 3) begin
                        rq[mi].push_back(8'($urandom));
                        enq++;
                    end
                end
            end
            wait_idle("rand_done");
            check("rand_acks", ack_total - b_tot, enq);
            check("rand_wr", wr_cnt - b_wr, enq * WPB);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single `tt_um_jminz_uart` transmitter among up to NREQ byte-producing requesters. Each grant latches one requester's byte and issues a single-cycle `wr_en` pulse to the UART. The arbiter then tracks `tx_busy` through a full frame before it arbitrates again. The block sits between internal data sources and the UART `din`/`wr_en`/`tx_busy` pins; the UART receive path is not touched.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..16.
- IDW, 2: width of `grant_id`; must satisfy 2**IDW >= NREQ.
- START_TIMEOUT, 8: cycles allowed after `wr_en` for `tx_busy` to rise, 1..255.

Ports:
- clk_50m  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  NREQ  per-requester byte request, level.
- req_data  in  8*NREQ  byte for requester i is in bits [8i+7:8i].
- ack  out  NREQ  one-cycle pulse; byte of requester i has been latched.
- grant_id  out  IDW  index of the most recent grant.
- active  out  1  high whenever state is not IDLE.
- err_timeout  out  1  one-cycle pulse when `tx_busy` fails to rise within START_TIMEOUT.
- uart_din  out  8  to UART `din`.
- uart_wr_en  out  1  to UART `wr_en`; one-cycle pulse.
- uart_tx_busy  in  1  from UART `tx_busy`.

## Operation
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO. With UART_ARB_TAG_EN, the TAG_ISSUE, TAG_WAIT_HI and TAG_WAIT_LO states are added ahead of ISSUE.
- IDLE: when `uart_tx_busy`=0 and any `req` bit is set, select the winner by round-robin.
  - The search starts at `ptr+1` and wraps modulo NREQ.
  - On the grant edge: latch the winner's byte into the holding register, set `grant_id`, set `ptr`=winner, pulse `ack[winner]`, and go to ISSUE (or TAG_ISSUE).
- IDLE with `uart_tx_busy`=1 never grants. This makes the arbiter safe when reset is applied mid-frame.
- ISSUE: drive `uart_din` from the holding register, hold `uart_wr_en`=1 for this one cycle, clear the timeout counter, go to WAIT_HI.
- WAIT_HI:
  - If `uart_tx_busy`=1, go to WAIT_LO.
  - Otherwise increment the counter. When the counter reaches START_TIMEOUT, pulse `err_timeout` and go to IDLE.
- WAIT_LO: when `uart_tx_busy`=0, go to IDLE.
- Requester protocol:
  - Hold `req` and `req_data` stable until `ack` is seen.
  - `req` may stay high to queue the next byte; that requester then competes normally and yields to the others by rotation.
  - Dropping `req` before `ack` withdraws the request with no side effects.
- Reset values:
  - `ack`=0, `grant_id`=0, `active`=0, `err_timeout`=0.
  - `uart_din`=0, `uart_wr_en`=0.
  - `ptr`=NREQ-1, so requester 0 has first priority.
  - State = IDLE.
- Reset mid-operation: all outputs and state clear on the reset edge. A UART frame already in flight completes on its own; no new grant is issued until `tx_busy` falls.
- Only one `ack` bit may ever be high at a time. `uart_wr_en` and any `ack` bit are never high in the same cycle.

## Timing
- Cycle g, IDLE with request pending: `ack[i]`=1 and `grant_id` valid in cycle g+1.
- Cycle g+2 (ISSUE): `uart_wr_en`=1 and `uart_din` valid.
- Next arbitration: earliest in the cycle after WAIT_LO sees `tx_busy`=0.
- Back-to-back throughput is one byte per UART frame plus 3 cycles.
- `uart_din` holds its value after ISSUE until the next ISSUE.
- Timeout: `err_timeout` pulses START_TIMEOUT+1 cycles after the `wr_en` cycle, then the arbiter returns to IDLE. The latched byte is dropped; there is no retry.

## Configuration
- UART_ARB_TAG_EN defined:
  - Every grant first sends the tag byte 8'hF0 | grant_id through the TAG_ISSUE/TAG_WAIT_HI/TAG_WAIT_LO sequence, with the same rules as ISSUE/WAIT_HI/WAIT_LO.
  - The data byte follows.
  - `ack` still pulses at grant time.
  - A timeout on the tag byte aborts the data byte as well.
- Undefined: data bytes only; the tag states are absent.

## Test plan
- Single request, loopback UART: `req`=4'b0001, data 8'h5A -> `ack[0]` pulses exactly once, one `wr_en`, UART RX `dout`=8'h5A, `active` falls after `tx_busy` falls.
- All four requesters held high with data 8'h10..8'h13, eight bytes in total -> grant order 0,1,2,3,0,1,2,3; received bytes 10,11,12,13,10,11,12,13.
- UART model that holds `tx_busy` low, START_TIMEOUT=8 -> `err_timeout` pulses 9 cycles after `wr_en`, state returns to IDLE, next request is granted normally.
- `rst_n` low for 1 cycle in the middle of WAIT_LO while `tx_busy`=1, `req`=4'b0010 held -> outputs are 0; no grant until `tx_busy`=0; then `ack[1]` fires; the in-flight frame is received intact.
- Build with UART_ARB_TAG_EN, `req`=4'b0100, data 8'hC3 -> received byte stream F2, C3; exactly one `ack[2]` pulse.
- `req[3]` raised for one cycle while the arbiter is busy, then dropped -> no `ack[3]`, no extra `wr_en`.
